p2s_lane_scheduler: RTL and testbench

P2S_LANE_SCHEDULER -- requirements
Module: p2s_lane_scheduler

---
 rtl/p2s_lane_scheduler_if.sv | 25 ++
 rtl/p2s_lane_scheduler.sv | 120 ++++++++++++
 tb/tb_p2s_lane_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/p2s_lane_scheduler_if.sv
// Request-side byte lanes and nibble-stream handshake of the lane scheduler.
// master drives requests and downstream ready; slave is the scheduler itself.
interface p2s_lane_scheduler_if;
    logic [7:0] D0;
    logic [7:0] D1;
    logic [7:0] D2;
    logic [7:0] D3;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] data_out;
    logic [1:0] lane_id;
    logic [7:0] byte_cnt;

    modport master (
        output D0, D1, D2, D3, req_valid, out_ready,
        input  req_ready, out_valid, data_out, lane_id, byte_cnt
    );

    modport slave (
        input  D0, D1, D2, D3, req_valid, out_ready,
        output req_ready, out_valid, data_out, lane_id, byte_cnt
    );
endinterface

// File: rtl/p2s_lane_scheduler.sv
// Round-robin picks one of four byte lanes and serialises the byte as two nibbles, high first.
// Latency: grant is combinational; high nibble appears the cycle after grant, 2 cycles/byte back-to-back.
// Backpressure: out_ready=0 or ENB=0 holds the current nibble and blocks new grants.
module p2s_lane_scheduler (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    ENB,
    p2s_lane_scheduler_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_rr_ptr;
    logic [7:0] r_buf;
    logic [1:0] r_lane_id;
    logic [7:0] r_byte_cnt;

    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_offset;
    logic [1:0] w_grant;
    logic       w_grant_vld;
    logic [7:0] w_grant_dat;
    logic       w_take;
    logic       w_done;
    logic [3:0] w_data_out;

    // Rotating the request vector by rr_ptr turns round-robin into a fixed lowest-bit priority.
    assign w_dbl       = {bus.req_valid, bus.req_valid} >> r_rr_ptr;
    assign w_rot       = w_dbl[3:0];
    assign w_grant_vld = |bus.req_valid;
    assign w_grant     = r_rr_ptr + w_offset;

    always_comb begin
        w_offset = 2'd3;
        if (w_rot[0])      w_offset = 2'd0;
        else if (w_rot[1]) w_offset = 2'd1;
        else if (w_rot[2]) w_offset = 2'd2;
    end

    always_comb begin
        w_grant_dat = bus.D0;
        case (w_grant)
            2'd0: w_grant_dat = bus.D0;
            2'd1: w_grant_dat = bus.D1;
            2'd2: w_grant_dat = bus.D2;
            2'd3: w_grant_dat = bus.D3;
            default: w_grant_dat = bus.D0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (ENB && w_grant_vld) begin
                    w_take       = 1'b1;
                    w_next_state = HI;
                end
            end
            HI: begin
                if (ENB && bus.out_ready) w_next_state = LO;
            end
            LO: begin
                if (ENB && bus.out_ready) begin
                    w_done = 1'b1;
                    if (w_grant_vld) begin
                        w_take       = 1'b1;
                        w_next_state = HI;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 2'd0;
            r_buf      <= 8'd0;
            r_lane_id  <= 2'd0;
            r_byte_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_take) begin
                r_buf     <= w_grant_dat;
                r_lane_id <= w_grant;
                r_rr_ptr  <= w_grant + 2'd1;
            end
            if (w_done) r_byte_cnt <= r_byte_cnt + 8'd1;
        end
    end

    always_comb begin
        w_data_out = 4'd0;
        case (r_state)
            HI:      w_data_out = r_buf[7:4];
            LO:      w_data_out = r_buf[3:0];
            default: w_data_out = 4'd0;
        endcase
    end

    assign bus.req_ready = (w_take && !reset) ? (4'b0001 << w_grant) : 4'b0000;
    assign bus.out_valid = ENB && (r_state != IDLE);
    assign bus.data_out  = w_data_out;
    assign bus.lane_id   = r_lane_id;
    assign bus.byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_p2s_lane_scheduler.sv
// Bench for p2s_lane_scheduler: cycle vector table plus scoreboarded round-robin, stall and wrap runs.
module tb_p2s_lane_scheduler;

    logic CLK = 1'b0;
    logic reset;
    logic ENB;

    always #5 CLK = ~CLK;

    p2s_lane_scheduler_if bus();

    p2s_lane_scheduler dut (
        .CLK   (CLK),
        .reset (reset),
        .ENB   (ENB),
        .bus   (bus)
    );

    typedef struct {
        int rst, enb, rv, ordy, d0, d1, d2, d3;
        int x_rdy, x_ov, x_dat, x_lane, x_cnt;
    } vec_t;

    vec_t tbl[28];
    int   n_vec = 0;
    int   n_err = 0;
    int   sb[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input int r, input int e, input int rv, input int o,
                         input int a, input int b, input int c, input int d);
        reset         = (r != 0);
        ENB           = (e != 0);
        bus.req_valid = 4'(rv);
        bus.out_ready = (o != 0);
        bus.D0        = 8'(a);
        bus.D1        = 8'(b);
        bus.D2        = 8'(c);
        bus.D3        = 8'(d);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        @(negedge CLK);
    endtask

    // Entries encode lane*16 + nibble.
    task automatic push_byte(input int lane, input int b);
        sb.push_back(lane * 16 + ((b >> 4) & 15));
        sb.push_back(lane * 16 + (b & 15));
    endtask

    task automatic pop_check(input string nm, input int idx);
        int e;
        if (sb.size() == 0) begin
            chk({nm, "_extra"}, idx, 32'(bus.data_out), 32'hFFFF);
        end else begin
            e = sb.pop_front();
            chk({nm, "_nib"},  idx, 32'(bus.data_out), 32'(e & 15));
            chk({nm, "_lane"}, idx, 32'(bus.lane_id),  32'(e >> 4));
        end
    endtask

    initial begin
        //          rst enb rv    ordy d0     d1     d2     d3      rdy  ov dat  lane cnt
        tbl[0]  = '{1, 1, 'h1, 1, 'h5A, 0,     0,     0,      0,   0, 0,   0, 0};
        tbl[1]  = '{0, 1, 'h1, 1, 'h5A, 0,     0,     0,      'h1, 0, 0,   0, 0};
        tbl[2]  = '{0, 1, 'h0, 1, 'h5A, 0,     0,     0,      0,   1, 'h5, 0, 0};
        tbl[3]  = '{0, 1, 'h0, 1, 'h00, 0,     0,     0,      0,   1, 'hA, 0, 0};
        tbl[4]  = '{0, 1, 'h0, 1, 0,    0,     0,     0,      0,   0, 0,   0, 1};
        tbl[5]  = '{0, 1, 'h4, 0, 0,    0,     'hFE,  0,      'h4, 0, 0,   0, 1};
        tbl[6]  = '{0, 1, 'h8, 0, 0,    0,     'h00,  'h77,   0,   1, 'hF, 2, 1};
        tbl[7]  = '{0, 1, 'h8, 0, 0,    0,     'h11,  'h77,   0,   1, 'hF, 2, 1};
        tbl[8]  = '{0, 1, 'h8, 0, 0,    0,     'h22,  'h77,   0,   1, 'hF, 2, 1};
        tbl[9]  = '{0, 1, 'h8, 1, 0,    0,     0,     'h77,   0,   1, 'hF, 2, 1};
        tbl[10] = '{0, 1, 'h8, 1, 0,    0,     0,     'h77,   'h8, 1, 'hE, 2, 1};
        tbl[11] = '{0, 1, 'h0, 1, 0,    0,     0,     'h99,   0,   1, 'h7, 3, 2};
        tbl[12] = '{0, 1, 'h0, 1, 0,    0,     0,     0,      0,   1, 'h7, 3, 2};
        tbl[13] = '{0, 1, 'h1, 1, 'hC3, 0,     0,     0,      'h1, 0, 0,   3, 3};
        tbl[14] = '{0, 1, 'h0, 1, 'h55, 0,     0,     0,      0,   1, 'hC, 0, 3};
        tbl[15] = '{0, 0, 'h2, 1, 0,    'h11,  0,     0,      0,   0, 'h3, 0, 3};
        tbl[16] = '{0, 0, 'h2, 1, 0,    'h11,  0,     0,      0,   0, 'h3, 0, 3};
        tbl[17] = '{0, 1, 'h0, 1, 0,    0,     0,     0,      0,   1, 'h3, 0, 3};
        tbl[18] = '{0, 0, 'hF, 1, 'h12, 'h34,  'h56,  'h78,   0,   0, 0,   0, 4};
        tbl[19] = '{0, 1, 'h4, 1, 0,    0,     'h89,  0,      'h4, 0, 0,   0, 4};
        tbl[20] = '{0, 1, 'h0, 1, 0,    0,     'h89,  0,      0,   1, 'h8, 2, 4};
        tbl[21] = '{1, 1, 'hA, 1, 0,    'hAB,  'h89,  'hCD,   0,   1, 'h9, 2, 4};
        tbl[22] = '{0, 1, 'hA, 1, 0,    'hAB,  0,     'hCD,   'h2, 0, 0,   0, 0};
        tbl[23] = '{0, 1, 'hA, 1, 0,    'hAB,  0,     'hCD,   0,   1, 'hA, 1, 0};
        tbl[24] = '{0, 1, 'hA, 1, 0,    'hAB,  0,     'hCD,   'h8, 1, 'hB, 1, 0};
        tbl[25] = '{0, 1, 'h0, 1, 0,    0,     0,     0,      0,   1, 'hC, 3, 1};
        tbl[26] = '{0, 1, 'h0, 1, 0,    0,     0,     0,      0,   1, 'hD, 3, 1};
        tbl[27] = '{0, 1, 'h0, 1, 0,    0,     0,     0,      0,   0, 0,   3, 2};

        drive(1, 1, 0, 1, 0, 0, 0, 0);
        @(negedge CLK);
        @(negedge CLK);

        // Vector table: inputs applied after negedge, outputs checked before the next posedge.
        for (int i = 0; i < 28; i++) begin
            if (i != 0) @(negedge CLK);
            drive(tbl[i].rst, tbl[i].enb, tbl[i].rv, tbl[i].ordy,
                  tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
            #1;
            chk("req_ready", i, 32'(bus.req_ready), tbl[i].x_rdy);
            chk("out_valid", i, 32'(bus.out_valid), tbl[i].x_ov);
            chk("data_out",  i, 32'(bus.data_out),  tbl[i].x_dat);
            chk("lane_id",   i, 32'(bus.lane_id),   tbl[i].x_lane);
            chk("byte_cnt",  i, 32'(bus.byte_cnt),  tbl[i].x_cnt);
        end

        // Round robin with all lanes requesting: grants 0,1,2,3,0 with no idle cycle.
        begin
            int nibs;
            int gaps;
            bit started;
            nibs = 0; gaps = 0; started = 0;
            sb.delete();
            do_reset();
            drive(0, 1, 'hF, 1, 'h01, 'h23, 'h45, 'h67);
            for (int k = 0; k < 5; k++) push_byte(k % 4, 'h01 + 'h22 * (k % 4));
            for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
                #1;
                if (bus.req_ready != 4'b0000)
                    chk("rr_onehot", cyc, 32'($onehot(bus.req_ready)), 32'd1);
                if (started && !bus.out_valid) gaps++;
                if (bus.out_valid && bus.out_ready) begin
                    started = 1;
                    if (nibs == 8) chk("rr_cnt4", cyc, 32'(bus.byte_cnt), 32'd4);
                    pop_check("rr", nibs);
                    nibs++;
                end
                @(negedge CLK);
            end
            chk("rr_drain", 0, 32'(sb.size()), 32'd0);
            chk("rr_gaps",  0, 32'(gaps), 32'd0);
        end

        // Random out_ready/ENB stalls must not reorder, drop or duplicate nibbles.
        begin
            int nibs;
            nibs = 0;
            sb.delete();
            do_reset();
            drive(0, 1, 'hF, 1, 'h01, 'h23, 'h45, 'h67);
            for (int k = 0; k < 20; k++) push_byte(k % 4, 'h01 + 'h22 * (k % 4));
            for (int cyc = 0; cyc < 800 && sb.size() > 0; cyc++) begin
                ENB           = ($urandom_range(0, 3) != 0);
                bus.out_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (bus.out_valid && bus.out_ready) begin
                    pop_check("stall", nibs);
                    nibs++;
                end
                @(negedge CLK);
            end
            chk("stall_drain", 0, 32'(sb.size()), 32'd0);
            ENB = 1'b0;
            #1;
            chk("stall_cnt20", 0, 32'(bus.byte_cnt), 32'd20);
            chk("stall_ov_off", 0, 32'(bus.out_valid), 32'd0);
            @(negedge CLK);
            #1;
            chk("stall_frozen", 0, 32'(bus.byte_cnt), 32'd20);
        end

        // 256 bytes on lane 0 with D0 changing every cycle: captured byte must stay intact, count wraps.
        begin
            int nibs;
            nibs = 0;
            sb.delete();
            do_reset();
            drive(0, 1, 'h1, 1, 0, 0, 0, 0);
            for (int cyc = 0; cyc < 700 && nibs < 512; cyc++) begin
                bus.D0 = 8'($urandom);
                #1;
                if (nibs == 510) chk("wrap_cnt255", cyc, 32'(bus.byte_cnt), 32'd255);
                if (bus.out_valid && bus.out_ready) begin
                    pop_check("wrap", nibs);
                    nibs++;
                end
                if (bus.req_ready[0]) push_byte(0, int'(bus.D0));
                @(negedge CLK);
            end
            chk("wrap_nibs", 0, 32'(nibs), 32'd512);
            #1;
            chk("wrap_cnt0", 0, 32'(bus.byte_cnt), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
